fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation Atom core. It replaces the single-cycle PC plus instruction-register fetch with a request/acknowledge instruction-memory interface that tolerates wait states. A prefetch buffer of configurable depth decouples fetch from decode, and a redirect port flushes the buffer and discards stale responses. It sits between instruction memory/bus and the decode/execute stage.

Parameters:
RESET_PC, 32'h0001_0000, first fetch address after reset
PREFETCH_DEPTH, 2, prefetch buffer entries; power of two, minimum 2
ADDR_WIDTH, 32, PC/address width

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous reset, active-low
hlt_i  in  1  halt: no new requests issued; an in-flight request still completes
jump_en_i  in  1  redirect request from execute stage
jump_addr_i  in  ADDR_WIDTH  redirect target
imem_req_o  out  1  instruction memory request valid
imem_addr_o  out  ADDR_WIDTH  request address
imem_ack_i  in  1  response valid; may be asserted in the same cycle as the request
imem_data_i  in  32  response instruction word
instr_valid_o  out  1  buffer head valid
instr_o  out  32  buffer head instruction
instr_pc_o  out  ADDR_WIDTH  PC of head instruction
instr_ready_i  in  1  decode consumes the head when valid && ready
fetch_pc_o  out  ADDR_WIDTH  next PC to be requested (debug/trace)

Behaviour:
- Reset values (asserted asynchronously):
  - imem_req_o=0, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), instr_pc_o=0.
  - fetch_pc=RESET_PC, buffer empty, outstanding=0, discard=0.
- At most one outstanding request.
- Issue condition: !hlt_i && !outstanding && (count + outstanding) < PREFETCH_DEPTH && !(discard pending).
- Once imem_req_o rises, it and imem_addr_o stay stable until the ack cycle. A request is never withdrawn, including on redirect or halt.
- Ack in the same cycle as the request: the transaction completes that cycle, and the next request may issue the following cycle. Sustained throughput is 1 instruction per cycle with zero-wait memory.
- Ack with discard clear:
  - Push {fetch address, imem_data_i} into the buffer.
  - fetch_pc += 4.
  - Entry becomes visible on instr_valid_o the next cycle. Latency from request-with-ack to instr_valid_o is 1 cycle.
- Ack with discard set: data dropped, discard cleared, fetch_pc unchanged.
- Redirect (jump_en_i=1), in the same cycle:
  - Buffer flushed; the head is not consumed even if instr_ready_i=1.
  - fetch_pc <= {jump_addr_i[ADDR_WIDTH-1:1],1'b0}.
  - If a request is outstanding and not acked this cycle, discard is set.
  - If acked this cycle, the ack data is dropped.
- Redirect has priority over push, pop, and the fetch_pc increment.
- Redirect while hlt_i=1: PC updates, no request issued until hlt_i falls.
- Simultaneous push and pop with the buffer full: not possible, because the issue condition reserves a slot.
- Simultaneous push and pop otherwise: count is unchanged.
- Buffer pointers wrap modulo PREFETCH_DEPTH.
- fetch_pc wraps modulo 2^ADDR_WIDTH.
- Reset asserted mid-transaction: all state clears. An imem_ack_i arriving with outstanding=0 is ignored.
- Outputs instr_* are taken from registered buffer storage; there is no combinational path from imem_data_i.

Optional Feature:
FETCH_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt_o[31:0], reset 0.
  - Increments each cycle instr_ready_i=1 && instr_valid_o=0 && !jump_en_i.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header `atom_pkg`:
  - NOP constant 32'h0000_0013
  - default RESET_PC
  - PC increment constant 4
- One sub-module, fetch_buffer:
  - Synchronous FIFO of {ADDR_WIDTH+32}-bit entries, depth PREFETCH_DEPTH.
  - Ports: push, pop, flush, full, empty, count, head.
  - Flush has priority over push/pop.
- fetch_unit holds fetch_pc, the outstanding/discard flags, and the issue logic.

Test Plan:
1. Zero-wait memory (ack=req combinationally), instr_ready_i=1 → after rst_i release, instr_pc_o sequence 0x10000, 0x10004, 0x10008 on consecutive cycles; instr_valid_o high from cycle 2 onward.
2. Memory with 3-cycle ack latency, DEPTH=2, instr_ready_i=0 → exactly 2 requests accepted, then imem_req_o stays 0. Count holds at 2 until a pop frees a slot.
3. Redirect to 0x2002 while a request to 0x10004 is outstanding → its later ack is dropped. Next request address is 0x2002; the first delivered instr_pc_o is 0x2002.
4. jump_en_i in the same cycle as ack and pop, with 2 entries buffered → buffer empty next cycle, no instruction delivered from the old stream.
5. hlt_i=1 with one request outstanding → the ack is still buffered, no new imem_req_o. After hlt_i=0, the request issues on the next cycle.
6. With FETCH_STALL_CNT_EN: instr_ready_i=1 and 3-cycle memory latency over 10 cycles → stall_cnt_o matches the cycles with valid=0; reset mid-run returns it to 0.

Source files
------------

// File: rtl/atom_pkg.sv
// atom_pkg: constants shared by the Atom fetch front end.
package atom_pkg;

  // Canonical NOP (addi x0, x0, 0); shown on the instruction outputs out of reset.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // First fetch address after reset unless the instantiation overrides it.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0001_0000;

  // Sequential fetch stride in bytes.
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous prefetch FIFO of {pc, instruction} entries.
// Flush has priority over push and pop. Pointers wrap modulo DEPTH, and
// DEPTH must be a power of two.
module fetch_buffer
  import atom_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  localparam int EW   = AW + 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [EW-1:0] push_data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [PW:0]   count_o,
  output logic [EW-1:0] head_o
);

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // Overflowing or underflowing the storage is never allowed, even if the caller misbehaves.
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;

  assign full_o  = (r_count == (PW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  // Pointer, occupancy and storage update; flush empties the buffer in one cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {{AW{1'b0}}, NOP_INSTR};
      end
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data_i;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a req/ack memory port, a
// prefetch buffer and a redirect port.
// Optional build macro FETCH_STALL_CNT_EN adds stall_cnt_o, a saturating
// count of cycles where decode was ready but no instruction was valid.
//
// Handshakes:
//   imem: imem_req_o/imem_addr_o are held stable from the cycle the request
//     rises until the cycle imem_ack_i is seen high (ack may come in the
//     request's first cycle). A request is never withdrawn.
//   decode: the head transfers on a cycle where instr_valid_o && instr_ready_i
//     and jump_en_i is low; instr_* are stable while valid and not consumed.
module fetch_unit
  import atom_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    PREFETCH_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  hlt_i,
  input  logic                  jump_en_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [31:0]           imem_data_i,
  output logic                  instr_valid_o,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0]           stall_cnt_o,
`endif
  output logic [ADDR_WIDTH-1:0] fetch_pc_o
);

  localparam int CW = $clog2(PREFETCH_DEPTH) + 1;

  logic                   r_req;
  logic [ADDR_WIDTH-1:0]  r_req_addr;
  logic [ADDR_WIDTH-1:0]  r_fetch_pc;
  logic                   r_discard;

  logic                   w_ack;
  logic                   w_req_busy;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [CW-1:0]          w_count;
  logic [CW:0]            w_occ;
  logic                   w_slot_ok;
  logic                   w_issue;
  logic                   w_discard_nxt;
  logic [ADDR_WIDTH-1:0]  w_jump_pc;
  logic [ADDR_WIDTH-1:0]  w_fetch_pc_nxt;
  logic [ADDR_WIDTH+31:0] w_head;
  logic                   w_unused_jump_lsb;

  // Redirect targets are halfword aligned; bit 0 is dropped.
  assign w_jump_pc         = {jump_addr_i[ADDR_WIDTH-1:1], 1'b0};
  assign w_unused_jump_lsb = jump_addr_i[0];

  // Transaction bookkeeping: an ack only counts while a request is outstanding.
  assign w_ack      = r_req & imem_ack_i;
  assign w_req_busy = r_req & ~imem_ack_i;

  // Redirect wins over push, pop and the PC increment.
  assign w_push = w_ack & ~r_discard & ~jump_en_i & ~w_full;
  assign w_pop  = instr_valid_o & instr_ready_i & ~jump_en_i;

  // A request still open after a redirect must have its response thrown away.
  assign w_discard_nxt = jump_en_i ? w_req_busy : (r_discard & w_req_busy);

  // Occupancy after this edge; a new request needs a free slot reserved for its data.
  assign w_occ     = {1'b0, w_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};
  assign w_slot_ok = jump_en_i | (w_occ < (CW+1)'(PREFETCH_DEPTH));

  // Back-to-back issue is allowed in the ack cycle so zero-wait memory sustains 1/cycle.
  assign w_issue = ~hlt_i & ~w_req_busy & ~r_discard & w_slot_ok;

  assign w_fetch_pc_nxt = jump_en_i ? w_jump_pc :
                          w_push    ? r_fetch_pc + ADDR_WIDTH'(PC_INC) :
                                      r_fetch_pc;

  // Request, address, PC and discard state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_req      <= 1'b0;
      r_req_addr <= '0;
      r_fetch_pc <= RESET_PC;
      r_discard  <= 1'b0;
    end else begin
      r_req      <= w_issue | w_req_busy;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_discard  <= w_discard_nxt;
      if (w_issue) begin
        r_req_addr <= w_fetch_pc_nxt;
      end
    end
  end

  fetch_buffer #(
    .DEPTH (PREFETCH_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .flush_i     (jump_en_i),
    .push_data_i ({r_req_addr, imem_data_i}),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count),
    .head_o      (w_head)
  );

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_req_addr;
  assign instr_valid_o = ~w_empty;
  assign instr_pc_o    = w_head[ADDR_WIDTH+31:32];
  assign instr_o       = w_head[31:0];
  assign fetch_pc_o    = r_fetch_pc;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count decode-starved cycles, saturating at all ones; redirect cycles are excluded.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (instr_ready_i && !instr_valid_o && !jump_en_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
